alu_arbiter: RTL and testbench

- Shares the single registered alu between two requesters: requester 0 is the execute/integer path and requester 1 is the branch-compare path.
- Round-robin arbitration with a valid/ready request handshake.
- Ops are issued into the alu one per cycle and pipelined. Results come back to the originating requester on a fixed-latency response strobe.
- Sits between the decode/issue logic and the alu instance; it is the only driver of the alu's alu_op/a/b inputs.

---
 rtl/alu_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one registered alu between two requesters. Requester 0 is the
// execute/integer path and requester 1 is the branch-compare path.
// Arbitration is round-robin under contention. At most one op is issued
// per cycle. Results return after a fixed two-cycle latency on a per-requester
// response strobe.
//
// Ports:
//   clock, reset_n            system clock, synchronous active-low reset
//   reqK_valid/ready          request handshake for requester K (K = 0,1)
//   reqK_op/a/b               op code and operands for requester K
//   respK_valid               result for requester K is on resp_res/resp_cond
//   resp_res, resp_cond       shared result bus (straight from the alu)
//   alu_op, alu_a, alu_b      registered alu inputs (sole driver)
//   alu_res, alu_cond         alu outputs
//   busy                      an op is in flight
//
// Optional feature (macro ALU_ARB_LOCK_EN): adds req0_lock/req1_lock inputs
// and a lock FSM. A locking transfer from requester K gives K exclusive use
// of the alu until K makes a transfer with its lock bit clear.
module alu_arbiter #(
  parameter logic [3:0] IDLE_OP = 4'hF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
`ifdef ALU_ARB_LOCK_EN
  input  logic        req0_lock,
  input  logic        req1_lock,
`endif
  output logic        resp0_valid,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        resp1_valid,
  output logic [31:0] resp_res,
  output logic        resp_cond,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_res,
  input  logic        alu_cond,
  output logic        busy
);

  logic grant0;
  logic grant1;
  logic allow0;
  logic allow1;
  logic last_grant;
  logic s1_valid;
  logic s1_id;
  logic s2_valid;
  logic s2_id;

`ifdef ALU_ARB_LOCK_EN
  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED0  = 2'd1,
    LOCKED1  = 2'd2
  } lock_state_t;

  lock_state_t lock_state;
  lock_state_t lock_next;

  // Lock state register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lock_state <= UNLOCKED;
    end else begin
      lock_state <= lock_next;
    end
  end

  // A lock is taken and released only by a transfer from its owner
  always_comb begin
    lock_next = lock_state;
    case (lock_state)
      UNLOCKED: begin
        if (grant0 && req0_lock) begin
          lock_next = LOCKED0;
        end else if (grant1 && req1_lock) begin
          lock_next = LOCKED1;
        end
      end
      LOCKED0: begin
        if (grant0 && !req0_lock) begin
          lock_next = UNLOCKED;
        end
      end
      LOCKED1: begin
        if (grant1 && !req1_lock) begin
          lock_next = UNLOCKED;
        end
      end
      default: lock_next = UNLOCKED;
    endcase
  end

  // While locked, the non-owner is masked out even if the owner is idle
  always_comb begin
    allow0 = (lock_state != LOCKED1);
    allow1 = (lock_state != LOCKED0);
  end
`else
  assign allow0 = 1'b1;
  assign allow1 = 1'b1;
`endif

  // Round-robin grant. last_grant == 1 means requester 0 wins the next tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (reset_n) begin
      if (req0_valid && allow0 && req1_valid && allow1) begin
        if (last_grant) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
      end else if (req0_valid && allow0) begin
        grant0 = 1'b1;
      end else if (req1_valid && allow1) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Issue stage plus the id/valid pipeline tracking the alu's result register
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      alu_op     <= IDLE_OP;
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      s1_valid   <= 1'b0;
      s1_id      <= 1'b0;
      s2_valid   <= 1'b0;
      s2_id      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      if (grant0) begin
        alu_op     <= req0_op;
        alu_a      <= req0_a;
        alu_b      <= req0_b;
        s1_valid   <= 1'b1;
        s1_id      <= 1'b0;
        last_grant <= 1'b0;
      end else if (grant1) begin
        alu_op     <= req1_op;
        alu_a      <= req1_a;
        alu_b      <= req1_b;
        s1_valid   <= 1'b1;
        s1_id      <= 1'b1;
        last_grant <= 1'b1;
      end else begin
        alu_op   <= IDLE_OP;
        alu_a    <= 32'd0;
        alu_b    <= 32'd0;
        s1_valid <= 1'b0;
      end
    end
  end

  assign resp0_valid = s2_valid && (s2_id == 1'b0);
  assign resp1_valid = s2_valid && (s2_id == 1'b1);
  assign resp_res    = alu_res;
  assign resp_cond   = alu_cond;
  assign busy        = s1_valid | s2_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed vectors, scoreboard queue of expected
// responses and an independent monitor that checks each response strobe.
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_LT   = 4'h2;
  localparam logic [3:0] OP_EQ   = 4'h3;
  localparam logic [3:0] OP_NE   = 4'h4;
  localparam logic [3:0] IDLE_OP = 4'hF;

  typedef struct {
    logic        id;
    logic        chk_res;
    logic [31:0] res;
    logic        chk_cond;
    logic        cond;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp_res;
  logic        resp_cond;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_res;
  logic        alu_cond;
  logic        busy;
`ifdef ALU_ARB_LOCK_EN
  logic        req0_lock, req1_lock;
`endif

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  alu_arbiter #(.IDLE_OP(IDLE_OP)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
`ifdef ALU_ARB_LOCK_EN
    .req0_lock(req0_lock), .req1_lock(req1_lock),
`endif
    .resp0_valid(resp0_valid),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .resp1_valid(resp1_valid),
    .resp_res(resp_res), .resp_cond(resp_cond),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_res(alu_res), .alu_cond(alu_cond), .busy(busy)
  );

  // Simple registered alu: arithmetic updates res only, compares update cond only
  always_ff @(posedge clock) begin
    case (alu_op)
      OP_ADD:  alu_res  <= alu_a + alu_b;
      OP_SUB:  alu_res  <= alu_a - alu_b;
      OP_LT:   alu_cond <= ($signed(alu_a) < $signed(alu_b));
      OP_EQ:   alu_cond <= (alu_a == alu_b);
      OP_NE:   alu_cond <= (alu_a != alu_b);
      default: begin
        alu_res  <= 32'd0;
        alu_cond <= 1'b0;
      end
    endcase
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle of requests at the falling edge and checks the grants
  task automatic applyStimulus(input string name,
                               input logic v0, input logic [3:0] op0,
                               input logic [31:0] a0, input logic [31:0] b0,
                               input logic v1, input logic [3:0] op1,
                               input logic [31:0] a1, input logic [31:0] b1,
                               input logic exp_r0, input logic exp_r1);
    @(negedge clock);
    req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
    #1;
    checkOutput({name, "_ready0"}, {31'd0, req0_ready}, {31'd0, exp_r0});
    checkOutput({name, "_ready1"}, {31'd0, req1_ready}, {31'd0, exp_r1});
  endtask

  task automatic idleCycle(input string name);
    applyStimulus(name, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  task automatic pushExp(input logic id, input logic chk_res, input logic [31:0] res,
                         input logic chk_cond, input logic cond);
    exp_t e;
    e.id = id; e.chk_res = chk_res; e.res = res; e.chk_cond = chk_cond; e.cond = cond;
    sb.push_back(e);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // Monitor: every response strobe must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (resp0_valid || resp1_valid) begin
        checkOutput("resp_one_hot", {31'd0, resp0_valid & resp1_valid}, 32'd0);
        if (sb.size() == 0) begin
          checkOutput("resp_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("resp_id", {31'd0, resp1_valid}, {31'd0, e.id});
          if (e.chk_res) checkOutput("resp_res", resp_res, e.res);
          if (e.chk_cond) checkOutput("resp_cond", {31'd0, resp_cond}, {31'd0, e.cond});
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    req0_valid = 1'b0; req0_op = 4'h0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = 4'h0; req1_a = 32'd0; req1_b = 32'd0;
`ifdef ALU_ARB_LOCK_EN
    req0_lock = 1'b0; req1_lock = 1'b0;
`endif
    repeat (3) @(posedge clock);

    // Ready is held low during reset even with a valid request
    @(negedge clock);
    req0_valid = 1'b1;
    #1;
    checkOutput("rst_ready0", {31'd0, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_alu_op", {28'd0, alu_op}, {28'd0, IDLE_OP});
    checkOutput("rst_alu_a", alu_a, 32'd0);

    // Reset mid-flight drops the accepted op
    applyStimulus("mid_issue", 1'b1, OP_ADD, 32'd5, 32'd7, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    @(negedge clock);
    req0_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("mid_ready0", {31'd0, req0_ready}, 32'd0);
    @(negedge clock);
    checkOutput("mid_resp0", {31'd0, resp0_valid}, 32'd0);
    checkOutput("mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_alu_op", {28'd0, alu_op}, {28'd0, IDLE_OP});
    reset_n = 1'b1;
    idleCycle("mid_idle1");
    checkOutput("mid_resp0_late", {31'd0, resp0_valid}, 32'd0);
    idleCycle("mid_idle2");

    // Single requester, exact latency
    pushExp(1'b0, 1'b1, 32'd12, 1'b0, 1'b0);
    applyStimulus("single", 1'b1, OP_ADD, 32'd5, 32'd7, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    idleCycle("single_t1");
    checkOutput("single_t1_resp0", {31'd0, resp0_valid}, 32'd0);
    checkOutput("single_t1_busy", {31'd0, busy}, 32'd1);
    idleCycle("single_t2");
    checkOutput("single_t2_resp0", {31'd0, resp0_valid}, 32'd1);
    checkOutput("single_t2_res", resp_res, 32'd12);
    checkOutput("single_t2_resp1", {31'd0, resp1_valid}, 32'd0);
    repeat (2) idleCycle("single_drain");

    // Contention right after reset: grants 0,1,0,1
    doReset();
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) pushExp(1'b0, 1'b1, 32'd7, 1'b0, 1'b0);
      else            pushExp(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
      applyStimulus("contend", 1'b1, OP_SUB, 32'd10, 32'd3,
                    1'b1, OP_LT, 32'hFFFF_FFFF, 32'd0, (i % 2 == 0), (i % 2 == 1));
    end
    repeat (3) idleCycle("contend_drain");

    // Back-to-back compares from requester 1
    pushExp(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    applyStimulus("b2b_eq", 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, OP_EQ, 32'd4, 32'd4, 1'b0, 1'b1);
    pushExp(1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus("b2b_ne", 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, OP_NE, 32'd4, 32'd4, 1'b0, 1'b1);
    idleCycle("b2b_t2");
    checkOutput("b2b_first_resp1", {31'd0, resp1_valid}, 32'd1);
    idleCycle("b2b_t3");
    checkOutput("b2b_second_resp1", {31'd0, resp1_valid}, 32'd1);
    repeat (2) idleCycle("b2b_drain");

    // Requester 1 streams, requester 0 asks once and gets the next slot
    pushExp(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    applyStimulus("starve_a", 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, OP_EQ, 32'd1, 32'd1, 1'b0, 1'b1);
    pushExp(1'b0, 1'b1, 32'd5, 1'b0, 1'b0);
    applyStimulus("starve_b", 1'b1, OP_ADD, 32'd2, 32'd3, 1'b1, OP_EQ, 32'd1, 32'd1, 1'b1, 1'b0);
    pushExp(1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    applyStimulus("starve_c", 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, OP_EQ, 32'd1, 32'd1, 1'b0, 1'b1);
    repeat (3) idleCycle("starve_drain");

`ifdef ALU_ARB_LOCK_EN
    // Requester 1 locks for three ops while requester 0 waits
    doReset();
    req1_lock = 1'b1;
    pushExp(1'b1, 1'b1, 32'd2, 1'b0, 1'b0);
    applyStimulus("lock_1st", 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, OP_ADD, 32'd1, 32'd1, 1'b0, 1'b1);
    pushExp(1'b1, 1'b1, 32'd3, 1'b0, 1'b0);
    applyStimulus("lock_2nd", 1'b1, OP_ADD, 32'd5, 32'd7, 1'b1, OP_ADD, 32'd1, 32'd2, 1'b0, 1'b1);
    applyStimulus("lock_idle", 1'b1, OP_ADD, 32'd5, 32'd7, 1'b0, 4'h0, 32'd0, 32'd0, 1'b0, 1'b0);
    req1_lock = 1'b0;
    pushExp(1'b1, 1'b1, 32'd4, 1'b0, 1'b0);
    applyStimulus("lock_3rd", 1'b1, OP_ADD, 32'd5, 32'd7, 1'b1, OP_ADD, 32'd2, 32'd2, 1'b0, 1'b1);
    pushExp(1'b0, 1'b1, 32'd12, 1'b0, 1'b0);
    applyStimulus("lock_after", 1'b1, OP_ADD, 32'd5, 32'd7, 1'b0, 4'h0, 32'd0, 32'd0, 1'b1, 1'b0);
    repeat (3) idleCycle("lock_drain");
`endif

    checkOutput("scoreboard_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
